rect_plot_engine: RTL and testbench

- Downstream consumer of the screen-clear and cell-draw requests; sits directly upstream of the VGA adapter.
- Accepts one command at a time over a valid/ready handshake: either fill the whole 160x120 screen with one colour, or fill one CELL_SIZE x CELL_SIZE game-grid cell.
- Emits one pixel write (x, y, colour, plot) per clock, then pulses done.
- Replaces free-running clear scanners: exact pixel count, deterministic completion.

---
 rtl/draw_pkg.sv | 24 ++
 rtl/rect_scan_counter.sv | 73 +++++++
 rtl/rect_plot_engine.sv | 132 +++++++++++++
 tb/tb_rect_plot_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared constants and types for the pixel drawing path.
//   - Screen and grid geometry (160x120 screen, 4x4 cells, 40x30 grid).
//   - A few named 3-bit colours.
//   - State encoding for the rectangle plot engine FSM.
package draw_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int CELL_SIZE = 4;
  localparam int GRID_W    = SCREEN_W / CELL_SIZE;
  localparam int GRID_H    = SCREEN_H / CELL_SIZE;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Raster scanner over an inclusive rectangle [x0..x1] x [y0..y1].
// x is the inner loop, y the outer loop.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset (x=0, y=0)
//   load              : capture x0/y0/x1/y1; position becomes (x0,y0)
//   step              : advance one pixel (ignored while load is high)
//   x0, y0, x1, y1    : rectangle corners, sampled on load
//   x, y              : current pixel position (holds when not stepping)
//   last              : current position is the final pixel (x1,y1)
module rect_scan_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [7:0] x0_q, x0_d;
  logic [7:0] x1_q, x1_d;
  logic [6:0] y1_q, y1_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    if (load) begin
      x_d  = x0;
      y_d  = y0;
      x0_d = x0;
      x1_d = x1;
      y1_d = y1;
    end else if (step) begin
      // End of a row: wrap x back to the left edge and move down one line.
      if (x_q == x1_q) begin
        x_d = x0_q;
        y_d = y_q + 7'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/rect_plot_engine.sv
// Rectangle fill engine feeding the VGA adapter. Takes one command at a time
// (full-screen clear or one grid cell), emits one pixel write per clock, then
// pulses done for one cycle.
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
// all cmd_* fields are captured on that edge and later input changes are
// ignored. cmd_ready is high only in IDLE.
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   cmd_valid / cmd_ready         : command handshake
//   cmd_clear                     : 1 = whole screen, 0 = one cell
//   cmd_col, cmd_row              : cell coordinates (ignored for clear)
//   cmd_colour                    : fill colour
//   x, y, colour, plot            : pixel write to the VGA adapter
//   busy                          : high in PAINT or DONE
//   done                          : one-cycle completion pulse
module rect_plot_engine
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [5:0] cmd_col,
  input  logic [4:0] cmd_row,
  input  logic [2:0] cmd_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [2:0] colour_q, colour_d;

  logic       accept;
  logic       cell_in_range;
  logic       scan_load;
  logic       scan_step;
  logic       scan_last;
  logic [7:0] rect_x0, rect_x1;
  logic [6:0] rect_y0, rect_y1;

  always_comb begin
    cell_in_range = (cmd_col < 6'(GRID_W)) && (cmd_row < 5'(GRID_H));
    accept        = cmd_valid && (state_q == IDLE);

    // Cell corners; only meaningful for in-range cells, so the product never
    // exceeds 159/119 when it is actually loaded.
    if (cmd_clear) begin
      rect_x0 = 8'd0;
      rect_y0 = 7'd0;
      rect_x1 = 8'(SCREEN_W - 1);
      rect_y1 = 7'(SCREEN_H - 1);
    end else begin
      rect_x0 = 8'(cmd_col) * 8'(CELL_SIZE);
      rect_y0 = 7'(cmd_row) * 7'(CELL_SIZE);
      rect_x1 = rect_x0 + 8'(CELL_SIZE - 1);
      rect_y1 = rect_y0 + 7'(CELL_SIZE - 1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    colour_d  = colour_q;
    scan_load = 1'b0;
    scan_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          colour_d = cmd_colour;
          // An out-of-range cell has nothing to draw: complete immediately.
          if (cmd_clear || cell_in_range) begin
            scan_load = 1'b1;
            state_d   = PAINT;
          end else begin
            state_d   = DONE;
          end
        end
      end
      PAINT: begin
        if (scan_last) begin
          state_d = DONE;
        end else begin
          scan_step = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
    end
  end

  rect_scan_counter u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (scan_load),
    .step    (scan_step),
    .x0      (rect_x0),
    .y0      (rect_y0),
    .x1      (rect_x1),
    .y1      (rect_y1),
    .x       (x),
    .y       (y),
    .last    (scan_last)
  );

  // All outputs decode directly from registered state, so they are glitch-free
  // and change only on clock edges.
  assign cmd_ready = (state_q == IDLE);
  assign plot      = (state_q == PAINT);
  assign done      = (state_q == DONE);
  assign busy      = (state_q == PAINT) || (state_q == DONE);
  assign colour    = colour_q;

endmodule

// File: tb/tb_rect_plot_engine.sv
module tb_rect_plot_engine;
  import draw_pkg::*;

  localparam int W = 18;  // {x[7:0], y[6:0], colour[2:0]}
  localparam int N_CLEAR = 19200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [5:0] cmd_col;
  logic [4:0] cmd_row;
  logic [2:0] cmd_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  rect_plot_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_clear  (cmd_clear),
    .cmd_col    (cmd_col),
    .cmd_row    (cmd_row),
    .cmd_colour (cmd_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int plot_cnt = 0;
  logic [7:0] first_x, last_x;
  logic [6:0] first_y, last_y;
  logic [W-1:0] got_px, exp_px;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Pixel monitor: every plot pops one expected pixel.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && plot === 1'b1) begin
      got_px = {x, y, colour};
      if (plot_cnt == 0) begin
        first_x = x;
        first_y = y;
      end
      last_x = x;
      last_y = y;
      plot_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_extra: got x=%0d y=%0d c=%0d, expected no plot", x, y, colour);
      end else begin
        exp_px = exp_q.pop_front();
        if (got_px !== exp_px) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   x, y, colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
        end
      end
    end
  end

  // ---------------- model / drivers ----------------
  task automatic push_rect(input int fx, input int fy, input int lx, input int ly,
                           input logic [2:0] c);
    for (int yy = fy; yy <= ly; yy++)
      for (int xx = fx; xx <= lx; xx++)
        exp_q.push_back({8'(xx), 7'(yy), c});
  endtask

  task automatic drive_cmd(input logic clr, input logic [5:0] col, input logic [4:0] row,
                           input logic [2:0] c);
    cmd_clear  = clr;
    cmd_col    = col;
    cmd_row    = row;
    cmd_colour = c;
    cmd_valid  = 1'b1;
  endtask

  task automatic scramble_fields();
    cmd_clear  = 1'($urandom_range(0, 1));
    cmd_col    = 6'($urandom_range(0, 63));
    cmd_row    = 5'($urandom_range(0, 31));
    cmd_colour = 3'($urandom_range(0, 7));
  endtask

  // Called just after the accept edge. Checks no gaps in plot, cmd_ready low
  // while busy, done exactly at cycle n+1, cmd_ready back at n+2.
  task automatic wait_done(input int n, input string name);
    int  gaps = 0;
    int  not_busy = 0;
    int  k;
    int  done_at = -1;
    for (k = 1; k <= n + 50; k++) begin
      @(negedge clk); #1;
      if (k <= n && plot !== 1'b1) gaps++;
      if (cmd_ready !== 1'b0) not_busy++;
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    check({name, " done_cycle"}, done_at, n + 1);
    check({name, " plot_gaps"}, gaps, 0);
    check({name, " ready_while_busy"}, not_busy, 0);
    @(negedge clk); #1;
    check({name, " ready_after"}, cmd_ready, 1);
    check({name, " done_single"}, done, 0);
  endtask

  task automatic run_cmd(input logic clr, input logic [5:0] col, input logic [4:0] row,
                         input logic [2:0] c, input int n, input int fx, input int fy,
                         input int lx, input int ly, input string name);
    @(negedge clk); #1;
    check({name, " ready_before"}, cmd_ready, 1);
    plot_cnt = 0;
    if (n > 0) push_rect(fx, fy, lx, ly, c);
    drive_cmd(clr, col, row, c);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble_fields();
    wait_done(n, name);
    check({name, " plot_count"}, plot_cnt, n);
    check({name, " queue_empty"}, exp_q.size(), 0);
    check({name, " colour_hold"}, colour, c);
    if (n > 0) begin
      check({name, " first_x"}, first_x, fx);
      check({name, " first_y"}, first_y, fy);
      check({name, " last_x"}, last_x, lx);
      check({name, " last_y"}, last_y, ly);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       clr;
    logic [5:0] col;
    logic [4:0] row;
    logic [2:0] c;
    int         n;
    int         fx, fy, lx, ly;
    string      name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 6'd39, 5'd29, GREEN, 16, 156, 116, 159, 119, "cell_39_29"};
    vecs[1] = '{1'b1, 6'd0,  5'd0,  BLACK, N_CLEAR, 0, 0, 159, 119, "clear_black"};
    vecs[2] = '{1'b0, 6'd40, 5'd0,  RED,   0,   0,   0,   0,   0, "cell_col40"};
    vecs[3] = '{1'b0, 6'd0,  5'd29, RED,   16,  0, 116,   3, 119, "cell_0_29"};
    vecs[4] = '{1'b0, 6'd10, 5'd30, WHITE, 0,   0,   0,   0,   0, "cell_row30"};
    vecs[5] = '{1'b0, 6'd5,  5'd7,  WHITE, 16, 20,  28,  23,  31, "cell_5_7"};
    vecs[6] = '{1'b0, 6'd63, 5'd31, GREEN, 0,   0,   0,   0,   0, "cell_63_31"};

    cmd_valid  = 1'b0;
    cmd_clear  = 1'b0;
    cmd_col    = '0;
    cmd_row    = '0;
    cmd_colour = '0;

    // Reset held three cycles.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b1;
    check("rst plot", plot, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst x", x, 0);
    check("rst y", y, 0);
    check("rst colour", colour, 0);

    // Table-driven commands.
    for (int i = 0; i < 7; i++)
      run_cmd(vecs[i].clr, vecs[i].col, vecs[i].row, vecs[i].c, vecs[i].n,
              vecs[i].fx, vecs[i].fy, vecs[i].lx, vecs[i].ly, vecs[i].name);

    // Reset in the middle of a clear.
    begin
      int waited = 0;
      int spurious_done = 0;
      int spurious_plot = 0;
      @(negedge clk); #1;
      plot_cnt = 0;
      push_rect(0, 0, 159, 119, WHITE);
      drive_cmd(1'b1, 6'd0, 5'd0, WHITE);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      while (plot_cnt < 5000 && waited < 6000) begin
        @(negedge clk); #1;
        waited++;
      end
      check("abort reached_5000", plot_cnt, 5000);
      reset_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      reset_n = 1'b1;
      check("abort plot", plot, 0);
      check("abort done", done, 0);
      check("abort cmd_ready", cmd_ready, 1);
      check("abort x", x, 0);
      check("abort y", y, 0);
      repeat (5) begin
        @(negedge clk); #1;
        if (done !== 1'b0) spurious_done++;
        if (plot !== 1'b0) spurious_plot++;
      end
      check("abort no_done", spurious_done, 0);
      check("abort no_plot", spurious_plot, 0);
      run_cmd(1'b0, 6'd0, 5'd0, RED, 16, 0, 0, 3, 3, "after_abort");
      spurious_done = 0;
      repeat (4) begin
        @(negedge clk); #1;
        if (done !== 1'b0) spurious_done++;
      end
      check("after_abort one_done", spurious_done, 0);
    end

    // cmd_valid held high with fields changing during the first paint.
    @(negedge clk); #1;
    plot_cnt = 0;
    push_rect(48, 12, 51, 15, GREEN);
    drive_cmd(1'b0, 6'd12, 5'd3, GREEN);
    @(posedge clk); #1;
    push_rect(8, 80, 11, 83, WHITE);
    drive_cmd(1'b0, 6'd2, 5'd20, WHITE);
    wait_done(16, "held_a");
    check("held_a plot_count", plot_cnt, 16);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble_fields();
    wait_done(16, "held_b");
    check("held plot_count", plot_cnt, 32);
    check("held queue_empty", exp_q.size(), 0);
    check("held colour", colour, WHITE);
    check("held x_hold", x, 11);
    check("held y_hold", y, 83);

    check("final queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
